// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control unit with a variable-latency memory
// handshake, a wait-cycle timeout and a sticky error state.
//
// Optional feature: define MC_CTRL_PERF_EN to add the 32-bit retired
// instruction counter output 'instret'.
//
// Parameters:
//   TIMEOUT  max consecutive wait cycles in FETCH/MRD/MWR before ERR (1..255)
//   ALUOP_W  ALUOp width; codes occupy [2:0], upper bits driven 0 (>= 3)
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   op, funct       instruction opcode / funct from IR
//   Zero            ALU zero flag (branch decision)
//   mem_rdy         memory completes the current access this cycle
//   mem_req         memory access request
//   NPCOp           00 PC+4, 01 branch, 10 jump target, 11 register
//   PCWr, IRWr      PC / IR write enables
//   WDSel           00 ALU, 01 memory, 10 PC+4
//   RegDst          00 rt, 01 rd, 10 $31
//   RegWr           register file write enable
//   ExtOp           1 sign-extend, 0 zero-extend
//   ALUSelB         1 immediate, 0 register
//   ALUOp           000 add, 001 sub, 010 or, 011 slt, 100 lui
//   MemWr           data memory write
//   state_o         current state encoding
//   err             high while in ERR
//   instret         retired instruction count (MC_CTRL_PERF_EN only)

module mc_ctrl_fsm #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               Zero,
    input  logic               mem_rdy,
    output logic               mem_req,
    output logic [1:0]         NPCOp,
    output logic               PCWr,
    output logic               IRWr,
    output logic [1:0]         WDSel,
    output logic [1:0]         RegDst,
    output logic               RegWr,
    output logic               ExtOp,
    output logic               ALUSelB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               MemWr,
    output logic [3:0]         state_o,
    output logic               err
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]        instret
`endif
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;

    typedef enum logic [3:0] {
        FETCH = 4'd0,
        DCD   = 4'd1,
        MA    = 4'd2,
        MRD   = 4'd3,
        MWB   = 4'd4,
        MWR   = 4'd5,
        EXE   = 4'd6,
        ALUWB = 4'd7,
        BR    = 4'd8,
        JMP   = 4'd9,
        ERR   = 4'd10
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] wait_cnt;
    logic          wait_st;
    logic          timeout_hit;

    // ALU controls for ALU-class instructions, shared by EXE and ALUWB so the
    // operands stay stable through the write-back cycle.
    logic [2:0]    exe_alu;
    logic          exe_selb;
    logic          exe_ext;

    logic [2:0]    alu3;

    assign state_o     = state;
    assign wait_st     = (state == FETCH) || (state == MRD) || (state == MWR);
    assign timeout_hit = wait_st && !mem_rdy && (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        exe_alu  = ALU_ADD;
        exe_selb = 1'b0;
        exe_ext  = 1'b0;
        case (op)
            OP_R: begin
                case (funct)
                    FN_SUBU: exe_alu = ALU_SUB;
                    FN_SLT:  exe_alu = ALU_SLT;
                    default: exe_alu = ALU_ADD;
                endcase
            end
            OP_ORI: begin
                exe_alu  = ALU_OR;
                exe_selb = 1'b1;
            end
            OP_LUI: begin
                exe_alu  = ALU_LUI;
                exe_selb = 1'b1;
            end
            OP_ADDIU: begin
                exe_alu  = ALU_ADD;
                exe_selb = 1'b1;
                exe_ext  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Counter restarts whenever the state changes, so each memory wait is
    // timed independently.
    always_ff @(posedge clk) begin
        if (reset || (state_n != state)) begin
            wait_cnt <= '0;
        end else if (wait_st && !mem_rdy) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        mem_req = 1'b0;
        NPCOp   = 2'b00;
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        WDSel   = 2'b00;
        RegDst  = 2'b00;
        RegWr   = 1'b0;
        ExtOp   = 1'b0;
        ALUSelB = 1'b0;
        alu3    = ALU_ADD;
        MemWr   = 1'b0;
        err     = 1'b0;

        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_n = DCD;
                end else if (timeout_hit) begin
                    state_n = ERR;
                end
            end
            DCD: begin
                case (op)
                    OP_LW, OP_SW:               state_n = MA;
                    OP_ORI, OP_LUI, OP_ADDIU:   state_n = EXE;
                    OP_BEQ:                     state_n = BR;
                    OP_J, OP_JAL:               state_n = JMP;
                    OP_R: begin
                        case (funct)
                            FN_ADDU, FN_SUBU, FN_SLT: state_n = EXE;
                            FN_JR:                    state_n = JMP;
                            default:                  state_n = ERR;
                        endcase
                    end
                    default:                    state_n = ERR;
                endcase
            end
            MA: begin
                ALUSelB = 1'b1;
                ExtOp   = 1'b1;
                alu3    = ALU_ADD;
                state_n = (op == OP_LW) ? MRD : MWR;
            end
            MRD: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    state_n = MWB;
                end else if (timeout_hit) begin
                    state_n = ERR;
                end
            end
            MWB: begin
                RegWr   = 1'b1;
                WDSel   = 2'b01;
                RegDst  = 2'b00;
                state_n = FETCH;
            end
            MWR: begin
                mem_req = 1'b1;
                MemWr   = 1'b1;
                if (mem_rdy) begin
                    state_n = FETCH;
                end else if (timeout_hit) begin
                    state_n = ERR;
                end
            end
            EXE: begin
                alu3    = exe_alu;
                ALUSelB = exe_selb;
                ExtOp   = exe_ext;
                state_n = ALUWB;
            end
            ALUWB: begin
                alu3    = exe_alu;
                ALUSelB = exe_selb;
                ExtOp   = exe_ext;
                RegWr   = 1'b1;
                WDSel   = 2'b00;
                RegDst  = (op == OP_R) ? 2'b01 : 2'b00;
                state_n = FETCH;
            end
            BR: begin
                alu3    = ALU_SUB;
                ALUSelB = 1'b0;
                NPCOp   = 2'b01;
                PCWr    = Zero;
                state_n = FETCH;
            end
            JMP: begin
                PCWr = 1'b1;
                case (op)
                    OP_J: NPCOp = 2'b10;
                    OP_JAL: begin
                        NPCOp  = 2'b10;
                        RegWr  = 1'b1;
                        WDSel  = 2'b10;
                        RegDst = 2'b10;
                    end
                    default: NPCOp = 2'b11;
                endcase
                state_n = FETCH;
            end
            ERR: begin
                err = 1'b1;
            end
            default: begin
                state_n = ERR;
            end
        endcase

        // Reset overrides everything so an in-flight access never completes.
        if (reset) begin
            state_n = FETCH;
            mem_req = 1'b0;
            NPCOp   = 2'b00;
            PCWr    = 1'b0;
            IRWr    = 1'b0;
            WDSel   = 2'b00;
            RegDst  = 2'b00;
            RegWr   = 1'b0;
            ExtOp   = 1'b0;
            ALUSelB = 1'b0;
            alu3    = ALU_ADD;
            MemWr   = 1'b0;
            err     = 1'b0;
        end

        ALUOp      = '0;
        ALUOp[2:0] = alu3;
    end

`ifdef MC_CTRL_PERF_EN
    logic retire;

    assign retire = (state_n == FETCH) &&
                    ((state == MWB) || (state == MWR) || (state == ALUWB) ||
                     (state == BR)  || (state == JMP));

    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 32'd1;
        end
    end
`endif

endmodule
